// File: rtl/miss_counter_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : miss_counter_mmio_if
// Description : LC-3b style memory handshake bundle. The CPU side (master)
//               drives address, read/write strobes and write data and holds
//               them until mem_resp; the peripheral side (slave) returns
//               read data and a one-cycle completion pulse.
// Ports       : mem_address[15:0], mem_read, mem_write, mem_wdata[15:0]
//               (master -> slave); mem_rdata[15:0], mem_resp (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface miss_counter_mmio_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface
`default_nettype wire

// File: rtl/miss_counter_mmio.sv
`default_nettype none
// ============================================================================
// Module      : miss_counter_mmio
// Description : Memory-mapped front end for the free-running cache miss
//               counters. Brings the raw read/write miss counts into the clk
//               domain, and exposes software-clearable, freezable deltas plus
//               sticky overflow flags in an 8-byte window at BASE_ADDR.
// Ports       : clk, reset      - system clock, async active-high reset
//               read_miss[15:0] - raw read-miss count (asynchronous to clk)
//               write_miss[15:0]- raw write-miss count (asynchronous to clk)
//               bus (slave)     - LC-3b memory handshake
// Revision    : 1.0 - initial release
// ============================================================================
module miss_counter_mmio #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int unsigned SYNC_SETTLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         read_miss,
    input  logic [15:0]         write_miss,
    miss_counter_mmio_if.slave  bus
);

    localparam int unsigned        c_CNT_W      = (SYNC_SETTLE < 1) ? 1 : $clog2(SYNC_SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_MAX = c_CNT_W'(SYNC_SETTLE);
    localparam logic [1:0]         c_OFF_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_settle_cnt;

    logic [15:0] r_sync1_rd, r_sync2_rd, r_stable_rd, r_base_rd, r_prev_rd, r_snap_rd;
    logic [15:0] r_sync1_wr, r_sync2_wr, r_stable_wr, r_base_wr, r_prev_wr, r_snap_wr;
    logic [15:0] r_snap_tot;
    logic        r_ovf_rd, r_ovf_wr, r_frozen;

    // Access captured when accepted, so RESP does not depend on the CPU
    // still holding its request lines stable.
    logic [1:0]  r_off;
    logic        r_is_wr;
    logic [2:0]  r_wdata;

    logic [15:0] w_delta_rd, w_delta_wr, w_total, w_rdata;
    logic        w_in_window, w_req, w_accept, w_init_done;
    logic        w_ctrl_wr, w_clear, w_ovf_clr, w_freeze_rise;
    logic        w_unused;

    assign w_unused    = ^{bus.mem_address[0], bus.mem_wdata[15:3]};

    assign w_in_window = (bus.mem_address[15:3] == BASE_ADDR[15:3]);
    assign w_req       = (bus.mem_read || bus.mem_write) && w_in_window;

    assign w_delta_rd  = r_stable_rd - r_base_rd;
    assign w_delta_wr  = r_stable_wr - r_base_wr;
    assign w_total     = w_delta_rd + w_delta_wr;

    // Write side effects commit on the edge that ends the RESP cycle.
    assign w_ctrl_wr     = (r_state == ST_RESP) && r_is_wr && (r_off == c_OFF_CTRL);
    assign w_clear       = w_ctrl_wr && r_wdata[0];
    assign w_ovf_clr     = w_ctrl_wr && (r_wdata[0] || r_wdata[2]);
    assign w_freeze_rise = w_ctrl_wr && r_wdata[1] && !r_frozen;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_INIT) && !w_init_done) begin
                r_settle_cnt <= r_settle_cnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_init_done = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_settle_cnt == c_SETTLE_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_init_done = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_RESP;
                    w_accept    = 1'b1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_off   <= 2'd0;
            r_is_wr <= 1'b0;
            r_wdata <= 3'd0;
        end else if (w_accept) begin
            r_off   <= bus.mem_address[2:1];
            // Simultaneous read and write: the read wins, the write is dropped.
            r_is_wr <= bus.mem_write && !bus.mem_read;
            r_wdata <= bus.mem_wdata[2:0];
        end
    end

    // ------------------------------------------------------------------
    // Synchronizers: stable only follows the synchronizer once two
    // consecutive samples agree, filtering counts caught mid-transition.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1_rd  <= '0;
            r_sync2_rd  <= '0;
            r_stable_rd <= '0;
            r_sync1_wr  <= '0;
            r_sync2_wr  <= '0;
            r_stable_wr <= '0;
        end else begin
            r_sync1_rd <= read_miss;
            r_sync2_rd <= r_sync1_rd;
            r_sync1_wr <= write_miss;
            r_sync2_wr <= r_sync1_wr;
            if (r_sync1_rd == r_sync2_rd) r_stable_rd <= r_sync2_rd;
            if (r_sync1_wr == r_sync2_wr) r_stable_wr <= r_sync2_wr;
        end
    end

    // ------------------------------------------------------------------
    // Baseline, overflow, freeze and snapshot state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base_rd  <= '0;
            r_base_wr  <= '0;
            r_prev_rd  <= '0;
            r_prev_wr  <= '0;
            r_ovf_rd   <= 1'b0;
            r_ovf_wr   <= 1'b0;
            r_frozen   <= 1'b0;
            r_snap_rd  <= '0;
            r_snap_wr  <= '0;
            r_snap_tot <= '0;
        end else begin
            if (w_init_done || w_clear) begin
                r_base_rd <= r_stable_rd;
                r_base_wr <= r_stable_wr;
                // Deltas drop to zero on rebaseline; zeroing the history keeps
                // an old 0xFFFF from looking like a wrap on the next cycle.
                r_prev_rd <= '0;
                r_prev_wr <= '0;
            end else begin
                r_prev_rd <= w_delta_rd;
                r_prev_wr <= w_delta_wr;
            end

            if (w_ovf_clr) begin
                r_ovf_rd <= 1'b0;
                r_ovf_wr <= 1'b0;
            end else begin
                if ((r_prev_rd == 16'hFFFF) && (w_delta_rd == 16'h0000)) r_ovf_rd <= 1'b1;
                if ((r_prev_wr == 16'hFFFF) && (w_delta_wr == 16'h0000)) r_ovf_wr <= 1'b1;
            end

            if (w_ctrl_wr) r_frozen <= r_wdata[1];

            // Clear is ordered before freeze, so clear+freeze snapshots zero.
            if (w_clear) begin
                r_snap_rd  <= '0;
                r_snap_wr  <= '0;
                r_snap_tot <= '0;
            end else if (w_freeze_rise) begin
                r_snap_rd  <= w_delta_rd;
                r_snap_wr  <= w_delta_wr;
                r_snap_tot <= w_total;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux: zero outside the response cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 16'h0000;
        if (r_state == ST_RESP) begin
            case (r_off)
                2'd0:    w_rdata = r_frozen ? r_snap_rd  : w_delta_rd;
                2'd1:    w_rdata = r_frozen ? r_snap_wr  : w_delta_wr;
                2'd2:    w_rdata = r_frozen ? r_snap_tot : w_total;
                default: w_rdata = {13'b0, r_frozen, r_ovf_wr, r_ovf_rd};
            endcase
        end
    end

    assign bus.mem_rdata = w_rdata;
    assign bus.mem_resp  = (r_state == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_miss_counter_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_miss_counter_mmio
// Description : Self-checking bench for miss_counter_mmio: vector table,
//               directed multi-cycle sequences and randomized traffic against
//               a behavioural model of the register window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miss_counter_mmio;

    localparam logic [15:0] c_BASE   = 16'hFF00;
    localparam int          c_SETTLE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_miss;
    logic [15:0] write_miss;

    miss_counter_mmio_if bus ();

    miss_counter_mmio #(
        .BASE_ADDR   (c_BASE),
        .SYNC_SETTLE (c_SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_miss  (read_miss),
        .write_miss (write_miss),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: settled raw counts, baselines, last observed deltas.
    logic [15:0] m_raw_r, m_raw_w, m_base_r, m_base_w, m_prev_r, m_prev_w;
    logic [15:0] m_snap_r, m_snap_w, m_snap_t;
    logic        m_frozen, m_ovf_r, m_ovf_w;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] off);
        logic [15:0] dr, dw;
        dr = m_raw_r - m_base_r;
        dw = m_raw_w - m_base_w;
        case (off)
            2'd0:    return m_frozen ? m_snap_r : dr;
            2'd1:    return m_frozen ? m_snap_w : dw;
            2'd2:    return m_frozen ? m_snap_t : 16'(dr + dw);
            default: return {13'b0, m_frozen, m_ovf_w, m_ovf_r};
        endcase
    endfunction

    task automatic model_reset();
        m_base_r = m_raw_r;  m_base_w = m_raw_w;
        m_prev_r = 16'h0;    m_prev_w = 16'h0;
        m_snap_r = 16'h0;    m_snap_w = 16'h0;  m_snap_t = 16'h0;
        m_frozen = 1'b0;     m_ovf_r  = 1'b0;   m_ovf_w  = 1'b0;
    endtask

    task automatic model_write(input logic [1:0] off, input logic [15:0] wd);
        logic [15:0] dr, dw;
        if (off == 2'd3) begin
            dr = m_raw_r - m_base_r;
            dw = m_raw_w - m_base_w;
            if (wd[0]) begin
                m_base_r = m_raw_r;  m_base_w = m_raw_w;
                m_ovf_r  = 1'b0;     m_ovf_w  = 1'b0;
                m_snap_r = 16'h0;    m_snap_w = 16'h0;  m_snap_t = 16'h0;
                m_prev_r = 16'h0;    m_prev_w = 16'h0;
            end else if (wd[1] && !m_frozen) begin
                m_snap_r = dr;  m_snap_w = dw;  m_snap_t = dr + dw;
            end
            m_frozen = wd[1];
            if (wd[2]) begin
                m_ovf_r = 1'b0;
                m_ovf_w = 1'b0;
            end
        end
    endtask

    // Drive new raw counts and hold them long enough to settle.
    task automatic set_raw(input logic [15:0] r, input logic [15:0] w);
        logic [15:0] dr, dw;
        @(negedge clk);
        read_miss  = r;
        write_miss = w;
        repeat (5) @(posedge clk);
        m_raw_r = r;
        m_raw_w = w;
        dr = m_raw_r - m_base_r;
        dw = m_raw_w - m_base_w;
        if (m_prev_r == 16'hFFFF && dr == 16'h0) m_ovf_r = 1'b1;
        if (m_prev_w == 16'hFFFF && dw == 16'h0) m_ovf_w = 1'b1;
        m_prev_r = dr;
        m_prev_w = dw;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, output logic got, output logic [15:0] data);
        got  = 1'b0;
        data = 16'h0;
        @(negedge clk);
        bus.mem_address = addr;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_wdata   = wd;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin
                got  = 1'b1;
                data = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (got) begin
            @(posedge clk); #1;
            check("resp_one_cycle", 16'(bus.mem_resp), 16'h0);
            check("rdata_idle_zero", bus.mem_rdata, 16'h0);
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
        logic        got;
        logic [15:0] data;
        access(1'b1, 1'b0, addr, 16'h0, got, data);
        check({name, "_resp"}, 16'(got), 16'h1);
        if (got) check(name, data, exp);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] wd, input string name);
        logic        got;
        logic [15:0] data;
        access(1'b0, 1'b1, addr, wd, got, data);
        check({name, "_resp"}, 16'(got), 16'h1);
        model_write(addr[2:1], wd);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        got;
        logic [15:0] data, addr, exp;
        logic [1:0]  off;
        int          op, k;
        logic        found;

        vecs[0] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 16'hFF02, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 16'hFF04, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 16'hFF06, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 16'hFF00, 16'hABCD, 16'h0000};
        vecs[5] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 16'hFF04, 16'h1234, 16'h0000};
        vecs[7] = '{1'b0, 16'hFF05, 16'h0000, 16'h0000};

        reset           = 1'b1;
        read_miss       = 16'h0010;
        write_miss      = 16'h0020;
        bus.mem_address = 16'h0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = 16'h0;
        m_raw_r = 16'h0010;
        m_raw_w = 16'h0020;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", 16'(bus.mem_resp), 16'h0);
        check("reset_rdata", bus.mem_rdata, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);

        // Baseline after INIT: everything reads zero; data-register writes
        // are acknowledged without effect.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d_wr", i));
            else            bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd", i));
        end

        // Count step and filtering of a count that never holds still.
        set_raw(16'h0015, 16'h0020);
        bus_read(16'hFF00, 16'h0005, "step_delta_r");
        bus_read(16'hFF04, 16'h0005, "step_total");
        fork
            begin
                for (int t = 0; t < 14; t++) begin
                    @(negedge clk);
                    read_miss = read_miss ^ 16'h00FF;
                end
            end
            begin
                @(posedge clk);
                bus_read(16'hFF00, 16'h0005, "toggle_hold_a");
                @(posedge clk);
                bus_read(16'hFF00, 16'h0005, "toggle_hold_b");
            end
        join
        repeat (5) @(posedge clk);

        // Freeze hides a write-miss increase until unfrozen.
        bus_write(16'hFF06, 16'h0002, "freeze");
        set_raw(16'h0015, 16'h0027);
        bus_read(16'hFF02, 16'h0000, "frozen_w");
        bus_read(16'hFF06, 16'h0004, "ctrl_frozen");
        bus_write(16'hFF06, 16'h0000, "unfreeze");
        bus_read(16'hFF02, 16'h0007, "unfrozen_w");

        // Wrap detection and ovf-only clear.
        set_raw(16'h0000, 16'h0027);
        bus_write(16'hFF06, 16'h0001, "clear");
        bus_read(16'hFF00, 16'h0000, "after_clear_r");
        set_raw(16'hFFFF, 16'h0027);
        bus_read(16'hFF00, 16'hFFFF, "delta_ffff");
        set_raw(16'h0000, 16'h0027);
        bus_read(16'hFF06, 16'h0001, "ovf_set");
        bus_write(16'hFF06, 16'h0004, "ovf_clr");
        bus_read(16'hFF06, 16'h0000, "ovf_cleared");

        // Clear and freeze together: snapshot reads zero.
        set_raw(16'h0005, 16'h0027);
        bus_write(16'hFF06, 16'h0003, "clr_frz");
        bus_read(16'hFF00, 16'h0000, "clrfrz_snap");
        bus_read(16'hFF06, 16'h0004, "clrfrz_ctrl");
        set_raw(16'h0008, 16'h0027);
        bus_read(16'hFF00, 16'h0000, "clrfrz_still");
        bus_write(16'hFF06, 16'h0000, "unfreeze2");
        bus_read(16'hFF00, 16'h0003, "after_unfreeze");

        // Out-of-window accesses never respond; read beats write.
        access(1'b1, 1'b0, 16'hFF08, 16'h0, got, data);
        check("oow_ff08", 16'(got), 16'h0);
        access(1'b0, 1'b1, 16'hFEFE, 16'h0001, got, data);
        check("oow_fefe", 16'(got), 16'h0);
        access(1'b1, 1'b1, 16'hFF06, 16'h0007, got, data);
        check("rdwr_resp", 16'(got), 16'h1);
        check("rdwr_data", data, 16'h0000);
        bus_read(16'hFF06, 16'h0000, "rdwr_ctrl_kept");
        bus_read(16'hFF00, 16'h0003, "rdwr_r_kept");

        // Reset in the middle of a response.
        @(negedge clk);
        bus.mem_address = 16'hFF00;
        bus.mem_read    = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_resp", 16'(bus.mem_resp), 16'h1);
        reset = 1'b1;
        #1;
        check("async_reset_resp", 16'(bus.mem_resp), 16'h0);
        check("async_reset_rdata", bus.mem_rdata, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        found = 1'b0;
        k     = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin
                found = 1'b1;
                k     = c;
                break;
            end
        end
        data = bus.mem_rdata;
        bus.mem_read = 1'b0;
        check("post_reset_found", 16'(found), 16'h1);
        check("post_reset_ignored", 16'(k > c_SETTLE), 16'h1);
        check("post_reset_rebase", data, 16'h0000);
        repeat (2) @(posedge clk);

        // Randomized traffic against the model.
        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: set_raw(16'($urandom), 16'($urandom));
                1: begin
                    set_raw(m_base_r + 16'hFFFF, m_base_w + 16'hFFFF);
                    set_raw(m_base_r, m_base_w);
                end
                2, 3: begin
                    off  = 2'($urandom_range(0, 3));
                    addr = c_BASE | {13'b0, off, 1'b0} | 16'($urandom_range(0, 1));
                    exp  = m_read(off);
                    bus_read(addr, exp, "rand_read");
                end
                4: bus_write(16'hFF06, 16'($urandom_range(0, 7)), "rand_ctrl");
                5: bus_write(c_BASE | {13'b0, 2'($urandom_range(0, 2)), 1'b0}, 16'($urandom), "rand_data_wr");
                6: begin
                    addr = 16'($urandom);
                    if (addr[15:3] == c_BASE[15:3]) addr = addr ^ 16'h0008;
                    access(1'b1, 1'($urandom_range(0, 1)), addr, 16'h0007, got, data);
                    check("rand_oow", 16'(got), 16'h0);
                end
                default: begin
                    exp = m_read(2'd3);
                    access(1'b1, 1'b1, 16'hFF06, 16'($urandom_range(0, 7)), got, data);
                    check("rand_rdwr_resp", 16'(got), 16'h1);
                    check("rand_rdwr_data", data, exp);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
